// File: rtl/sram_bist_ctrl.sv
// March C- BIST initiator for a single-port SRAM with 2-cycle read latency; 4096 busy cycles per run.
// One outstanding access at a time; i_start is accepted only from IDLE/DONE and ignored while busy.
module sram_bist_ctrl #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 10,
  parameter logic [DATA_W-1:0] DATA_BG = 10'h000
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addra,
  output logic [DATA_W-1:0] o_dina,
  input  logic [DATA_W-1:0] i_douta,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [2:0]        o_fail_elem,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data,
  output logic [10:0]       o_err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WR0, S_RD0, S_RD1, S_WR, S_CHK, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic [10:0]         err_cnt_q, err_cnt_d;

  logic                down, last, mismatch;
  logic [ADDR_W-1:0]   addr_step;
  logic [DATA_W-1:0]   exp_rd;

  // Elements 3 and 4 walk downwards; everything else walks up.
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last      = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign addr_step = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
  assign exp_rd    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~DATA_BG : DATA_BG;
  assign mismatch  = ((state_q == S_WR) || (state_q == S_CHK)) && (i_douta != exp_rd);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_WR0;
          elem_d      = '0;
          addr_d      = '0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          err_cnt_d   = '0;
        end
      end
      S_WR0: begin
        if (last) begin
          state_d = S_RD0;
          elem_d  = 3'd1;
          addr_d  = '0;
        end else begin
          addr_d = addr_step;
        end
      end
      S_RD0: state_d = S_RD1;
      S_RD1: state_d = (elem_q == 3'd5) ? S_CHK : S_WR;
      S_WR: begin
        state_d = S_RD0;
        if (last) begin
          elem_d = elem_q + 3'd1;
          // Reload for the next element's direction: 3 and 4 start at the top.
          addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
        end else begin
          addr_d = addr_step;
        end
      end
      S_CHK: begin
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          elem_d  = '0;
          addr_d  = '0;
        end else begin
          state_d = S_RD0;
          addr_d  = addr_step;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (mismatch) begin
      err_cnt_d = err_cnt_q + 11'd1;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_elem_d = elem_q;
        fail_addr_d = addr_q;
        fail_data_d = i_douta;
      end
    end
  end

  assign o_ena       = (state_q == S_WR0) || (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_WR);
  assign o_wea       = (state_q == S_WR0) || (state_q == S_WR);
  assign o_addra     = addr_q;
  assign o_dina      = (state_q == S_WR0) ? DATA_BG :
                       (state_q == S_WR)  ? (((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~DATA_BG : DATA_BG) :
                       '0;
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done      = done_q;
  assign o_fail      = fail_q;
  assign o_fail_elem = fail_elem_q;
  assign o_fail_addr = fail_addr_q;
  assign o_fail_data = fail_data_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl against a 256x10 SRAM model with selectable faults.
module tb_sram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ena, wea;
  logic [7:0]  addra;
  logic [9:0]  dina;
  logic [9:0]  douta = '0;
  logic        busy, done, fail;
  logic [2:0]  fail_elem;
  logic [7:0]  fail_addr;
  logic [9:0]  fail_data;
  logic [10:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int fault = 0;  // 0 clean, 1 addr 5A bit3 stuck-at-1, 2 write to 01 also writes 00
  int cyc;

  logic [9:0] mem [256];
  logic [9:0] rd_q1 = '0;

  sram_bist_ctrl #(.ADDR_W(8), .DATA_W(10), .DATA_BG(10'h000)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start),
    .o_ena(ena), .o_wea(wea), .o_addra(addra), .o_dina(dina), .i_douta(douta),
    .o_busy(busy), .o_done(done), .o_fail(fail), .o_fail_elem(fail_elem),
    .o_fail_addr(fail_addr), .o_fail_data(fail_data), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // SRAM model: read registered twice, data valid two cycles after the access.
  always @(posedge clk) begin
    if (ena && !wea) rd_q1 <= (fault == 1 && addra == 8'h5A) ? (mem[addra] | 10'h008) : mem[addra];
    douta <= rd_q1;
    if (ena && wea) begin
      mem[addra] <= dina;
      if (fault == 2 && addra == 8'h01) mem[8'h00] <= dina;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns with cycles = number of busy cycles observed.
  task automatic run_bist(input int inject_at, input int abort_at, output int cycles);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 5000) begin
      if (cycles == 0) begin
        chk("start_clear", {done, fail, fail_elem, fail_addr, fail_data, err_cnt}, 32'h0);
        chk("first_w0", {ena, wea, addra, dina}, {2'b11, 8'h00, 10'h000});
      end
      if (cycles == 258) chk("e1_w1", {ena, wea, addra, dina}, {2'b11, 8'h00, 10'h3FF});
      if (cycles == 1792) chk("e3_first", {ena, wea, addra}, {2'b10, 8'hFF});
      if (cycles == 4095) chk("chk_idle_bus", {ena, addra}, {1'b0, 8'hFF});
      if (cycles == inject_at) start = 1'b1;
      if (cycles == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_out", {ena, wea, busy, done, fail, addra, dina}, 32'h0);
        chk("abort_res", {fail_elem, fail_addr, fail_data, err_cnt}, 32'h0);
        break;
      end
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {ena, wea, busy, done, fail, addra, dina, err_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    fault = 0;
    run_bist(-1, -1, cyc);
    chk("clean_cycles", cyc, 4096);
    chk("clean_res", {busy, done, fail, err_cnt}, {2'b01, 1'b0, 11'd0});

    fault = 1;
    run_bist(-1, -1, cyc);
    chk("stuck_cycles", cyc, 4096);
    chk("stuck_res", {done, fail, fail_elem, fail_addr, fail_data}, {2'b11, 3'd1, 8'h5A, 10'h008});
    chk("stuck_cnt", err_cnt, 3);

    // Restart after a failing run: cleared at start, clean at the end.
    fault = 0;
    run_bist(-1, -1, cyc);
    chk("restart_res", {cyc[12:0], done, fail, err_cnt}, {13'd4096, 2'b10, 11'd0});

    // The alias only bites when element 3 writes w1 at 01 just before reading 00 (descending),
    // and again in element 4; elements 1/2 reach 00 before 01 is written.
    fault = 2;
    run_bist(-1, -1, cyc);
    chk("alias_res", {fail, fail_elem, fail_addr, fail_data}, {1'b1, 3'd3, 8'h00, 10'h3FF});
    chk("alias_cnt", err_cnt, 2);

    fault = 0;
    run_bist(100, -1, cyc);
    chk("ign_start_cycles", cyc, 4096);
    chk("ign_start_res", {done, fail, err_cnt}, {2'b10, 11'd0});

    // Reset mid-run after a failure has been latched.
    fault = 1;
    run_bist(-1, 1999, cyc);
    chk("abort_cycle", cyc, 1999);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {busy, done, ena}, 32'h0);
    fault = 0;
    run_bist(-1, -1, cyc);
    chk("post_rst_cycles", cyc, 4096);
    chk("post_rst_res", {done, fail, err_cnt}, {2'b10, 11'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop guard: a bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
